serial_adder_fsm: RTL and testbench

//  Bit-serial WIDTH-bit adder with carry-in. Loads two operands on a start strobe,

---
 rtl/adder_pkg.sv | 16 +
 rtl/full_add_bit.sv | 50 +++++
 rtl/half_add.sv | 12 +
 rtl/serial_adder_fsm.sv | 119 +++++++++++
 tb/tb_serial_adder_fsm.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and the
// counter-width helper.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..width-1; never narrower than one bit.
    function automatic int CNT_W(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_add_bit.sv
// One-bit full adder from two half-add cells, owning the serial carry flop.
// The carry loads the carry-in at the start of an operation and advances per bit.
module full_add_bit (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic load_val_i,
    input  logic en_i,
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic carry_d_o,
    output logic carry_q_o
);

    logic p_bit;
    logic g0_bit;
    logic g1_bit;
    logic carry_q;
    logic carry_d;

    half_add u_ha0 (
        .a_i (a_i),
        .b_i (b_i),
        .s_o (p_bit),
        .c_o (g0_bit)
    );

    half_add u_ha1 (
        .a_i (p_bit),
        .b_i (carry_q),
        .s_o (s_o),
        .c_o (g1_bit)
    );

    assign carry_d   = g0_bit | g1_bit;
    assign carry_d_o = carry_d;
    assign carry_q_o = carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (load_i) begin
            carry_q <= load_val_i;
        end else if (en_i) begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/half_add.sv
// Combinational half-add cell: sum and carry of two bits.
module half_add (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder: loads operands on start, adds LSB-first one bit
// per clock, then presents sum/cout with a one-cycle done pulse.
module serial_adder_fsm
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = CNT_W(WIDTH);

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-2:0]   ps_q;
    logic [WIDTH-1:0]   ps_full;
    logic [WIDTH-1:0]   sum_q;
    logic [CW-1:0]      cnt_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    logic               load;
    logic               fa_en;
    logic               s_bit;
    logic               carry_d;
    logic               carry_q;
    logic               last_bit;

    assign load     = (state_q == ST_IDLE) && start;
    assign fa_en    = (state_q == ST_ADD);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Partial sum including the bit produced this cycle; on the last bit it is the result.
    assign ps_full  = {s_bit, ps_q};

    full_add_bit u_fa (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .load_val_i (cin),
        .en_i       (fa_en),
        .a_i        (a_sh_q[0]),
        .b_i        (b_sh_q[0]),
        .s_o        (s_bit),
        .carry_d_o  (carry_d),
        .carry_q_o  (carry_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    ps_q   <= ps_full[WIDTH-1:1];
                    if (last_bit) begin
                        sum_q   <= ps_full;
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

    // carry_q is observed through the full adder; keep it referenced for readability.
    logic carry_unused;
    assign carry_unused = carry_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm at WIDTH 8, 4 and 32 against an
// arithmetic reference ((a+b+cin) mod 2^W, carry at bit W) plus timing rules.
module tb_serial_adder_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_bus = '0;
    logic [31:0] b_bus = '0;
    logic        cin_bus = 1'b0;
    logic [2:0]  start_v = '0;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  cout_v;
    logic [7:0]  sum8;
    logic [3:0]  sum4;
    logic [31:0] sum32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_fsm #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_bus[7:0]), .b(b_bus[7:0]),
        .cin(cin_bus), .sum(sum8), .cout(cout_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    serial_adder_fsm #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_bus[3:0]), .b(b_bus[3:0]),
        .cin(cin_bus), .sum(sum4), .cout(cout_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    serial_adder_fsm #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_bus), .b(b_bus),
        .cin(cin_bus), .sum(sum32), .cout(cout_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    function automatic int width_of(input int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 4 : 32;
    endfunction

    function automatic logic [32:0] get_res(input int sel);
        logic [31:0] s;
        s = (sel == 0) ? {24'd0, sum8} : (sel == 1) ? {28'd0, sum4} : sum32;
        return {cout_v[sel], s};
    endfunction

    // Reference: plain unsigned addition, truncated to W bits, carry-out at bit 32 of the result word.
    function automatic logic [32:0] model(input int w, input logic [31:0] ai, input logic [31:0] bi, input logic ci);
        logic [32:0] full;
        logic [32:0] mask;
        full = {1'b0, ai} + {1'b0, bi} + {32'd0, ci};
        mask = (33'd1 << w) - 33'd1;
        return {full[w], (full[31:0] & mask[31:0])};
    endfunction

    task automatic run_op(input int sel, input logic [31:0] ai, input logic [31:0] bi, input logic ci,
                          input bit hold, input bit scramble, output logic [32:0] res,
                          output int lat, output int busy_cnt, output int done_cnt, output bit held_ok);
        logic [32:0] prev;
        prev = get_res(sel);
        @(negedge clk);
        a_bus = ai; b_bus = bi; cin_bus = ci; start_v[sel] = 1'b1;
        lat = -1; busy_cnt = 0; done_cnt = 0; held_ok = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (!hold) start_v[sel] = 1'b0;
            if (scramble && n == 3) begin
                a_bus = '1; b_bus = '1; cin_bus = 1'b1;
            end
            if (busy_v[sel]) busy_cnt++;
            if (done_v[sel]) begin
                done_cnt++;
                if (busy_v[sel]) held_ok = 1'b0;
                if (lat < 0) lat = n;
            end else if (lat < 0 && get_res(sel) !== prev) begin
                held_ok = 1'b0;
            end
            if (lat >= 0 && n > lat) break;
        end
        start_v[sel] = 1'b0;
        res = get_res(sel);
        $display("op w=%0d a=%h b=%h cin=%0d -> cout=%0d sum=%h lat=%0d", width_of(sel), ai, bi, ci,
                 res[32], res[31:0], lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({get_res(s), busy_v[s], done_v[s]} !== 35'd0) begin
                errors++;
                $display("FAIL reset w=%0d got res=%h busy=%0d done=%0d want all 0", width_of(s),
                         get_res(s), busy_v[s], done_v[s]);
            end
        end
        rst = 1'b0;
        $display("reset checked");
    endtask

    task automatic check_op8(input string name, input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                             input bit hold, input bit scramble);
        logic [32:0] res, exp;
        int lat, bc, dc;
        bit held;
        exp = model(8, {24'd0, ai}, {24'd0, bi}, ci);
        run_op(0, {24'd0, ai}, {24'd0, bi}, ci, hold, scramble, res, lat, bc, dc, held);
        checks++;
        if (res !== exp) begin
            errors++; $display("FAIL %s result got %h want %h", name, res, exp);
        end
        checks++;
        if (lat != 9) begin
            errors++; $display("FAIL %s done_latency got %0d want 9", name, lat);
        end
        checks++;
        if (bc != 8) begin
            errors++; $display("FAIL %s busy_cycles got %0d want 8", name, bc);
        end
        checks++;
        if (dc != 1) begin
            errors++; $display("FAIL %s done_pulses got %0d want 1", name, dc);
        end
        checks++;
        if (!held) begin
            errors++; $display("FAIL %s hold_prev got changed_or_overlap want held", name);
        end
    endtask

    task automatic test_basic();
        check_op8("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        check_op8("a5_5a_cin", 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_start();
        check_op8("held_start_scramble", 8'h12, 8'h34, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        int dones = 0;
        @(negedge clk);
        a_bus = 32'h77; b_bus = 32'h19; cin_bus = 1'b1; start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({get_res(0), busy_v[0], done_v[0]} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid_op got res=%h busy=%0d done=%0d want all 0", get_res(0), busy_v[0], done_v[0]);
        end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL reset_abort got %0d active_cycles want 0", dones);
        end
        $display("reset mid-op checked");
        check_op8("after_reset_03_04", 8'h03, 8'h04, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [32:0] r [3];
        logic [7:0]  oa [3];
        logic [7:0]  ob [3];
        logic        oc [3];
        logic [32:0] prev, exp;
        int idx;
        prev = get_res(0);
        for (int k = 0; k < 3; k++) begin
            oa[k] = 8'($urandom); ob[k] = 8'($urandom); oc[k] = 1'($urandom);
            r[k] = model(8, {24'd0, oa[k]}, {24'd0, ob[k]}, oc[k]);
        end
        @(negedge clk);
        for (int n = 0; n <= 30; n++) begin
            if (n > 0) begin
                @(negedge clk);
                idx = (n >= 9) ? (n - 9) / 10 : -1;
                exp = (idx < 0) ? prev : r[idx];
                checks++;
                if (get_res(0) !== exp || done_v[0] !== (n % 10 == 9)) begin
                    errors++;
                    $display("FAIL back_to_back n=%0d got res=%h done=%0d want res=%h done=%0d", n,
                             get_res(0), done_v[0], exp, (n % 10 == 9));
                end
            end
            if (n % 10 == 0 && n < 30) begin
                a_bus = {24'd0, oa[n/10]}; b_bus = {24'd0, ob[n/10]}; cin_bus = oc[n/10];
                start_v[0] = 1'b1;
                $display("op b2b a=%h b=%h cin=%0d", oa[n/10], ob[n/10], oc[n/10]);
            end
            if (n == 30) start_v[0] = 1'b0;
        end
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_exhaustive4();
        logic [32:0] res, exp;
        int lat, bc, dc;
        bit held;
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++) begin
                    exp = model(4, 32'(ia), 32'(ib), 1'(ic));
                    run_op(1, 32'(ia), 32'(ib), 1'(ic), 1'b0, 1'b0, res, lat, bc, dc, held);
                    checks++;
                    if (res !== exp || lat != 5) begin
                        errors++;
                        $display("FAIL w4 a=%0d b=%0d cin=%0d got %h lat=%0d want %h lat=5", ia, ib, ic, res, lat, exp);
                    end
                end
    endtask

    task automatic test_random32();
        logic [32:0] res, exp;
        logic [31:0] ra, rb;
        logic        rc;
        int lat, bc, dc;
        bit held;
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            if (k == 0) begin ra = '1; rb = '1; rc = 1'b1; end
            exp = model(32, ra, rb, rc);
            run_op(2, ra, rb, rc, 1'b0, 1'b0, res, lat, bc, dc, held);
            checks++;
            if (res !== exp || lat != 33 || bc != 32) begin
                errors++;
                $display("FAIL w32 a=%h b=%h cin=%0d got %h lat=%0d busy=%0d want %h lat=33 busy=32",
                         ra, rb, rc, res, lat, bc, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid_op();
        test_back_to_back();
        test_exhaustive4();
        test_random32();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
